// File: rtl/axis_data_unpack.sv
// Reassembles NUM_BEATS AXI-stream beats into one wide payload word
// plus an 8-bit sequence byte, with framing and sequence checking.
module axis_data_unpack #(
    parameter int DATA_WIDTH      = 4064,
    parameter int AXIS_DATA_WIDTH = 512
) (
    input  logic                         s_axis_h2c_aclk,
    input  logic                         s_axis_h2c_areset,
    input  logic [AXIS_DATA_WIDTH-1:0]   s_axis_h2c_tdata,
    input  logic [AXIS_DATA_WIDTH/8-1:0] s_axis_h2c_tkeep,
    input  logic                         s_axis_h2c_tlast,
    input  logic                         s_axis_h2c_tvalid,
    output logic                         s_axis_h2c_tready,
    output logic [DATA_WIDTH-1:0]        data,
    output logic                         data_valid,
    input  logic                         data_ready,
    output logic [7:0]                   seq_num,
    output logic                         frame_err,
    output logic                         seq_err,
    output logic [15:0]                  frame_cnt,
    output logic [1:0]                   ustate
);

    localparam int NUM_BEATS =
        (DATA_WIDTH + 8 + AXIS_DATA_WIDTH - 1) / AXIS_DATA_WIDTH;
    localparam int ASM_W = NUM_BEATS * AXIS_DATA_WIDTH;
    localparam int CW = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NUM_BEATS - 1);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ASM_W-1:0]      asm_q, asm_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [7:0]            seq_q, seq_d;
    logic [7:0]            exp_q, exp_d;
    logic                  dv_q, dv_d;
    logic                  ferr_q, ferr_d;
    logic                  serr_q, serr_d;
    logic [15:0]           fcnt_q, fcnt_d;

    logic accept;
    logic slot_free;
    logic load;
    logic unused_tkeep;

    // Byte enables carry no information: every beat is full width.
    assign unused_tkeep = ^s_axis_h2c_tkeep;

    assign s_axis_h2c_tready = ~s_axis_h2c_areset & (state_q != HOLD);
    assign accept    = s_axis_h2c_tvalid & s_axis_h2c_tready;
    assign slot_free = ~dv_q | data_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        asm_d   = asm_q;
        ferr_d  = 1'b0;
        load    = 1'b0;
        case (state_q)
            COLLECT: begin
                if (accept) begin
                    for (int k = 0; k < NUM_BEATS; k++) begin
                        if (cnt_q == CW'(k)) begin
                            asm_d[k*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH] =
                                s_axis_h2c_tdata;
                        end
                    end
                    if (cnt_q == LAST) begin
                        cnt_d = '0;
                        if (!s_axis_h2c_tlast) begin
                            ferr_d  = 1'b1;
                            state_d = DISCARD;
                        end else if (slot_free) begin
                            load = 1'b1;
                        end else begin
                            state_d = HOLD;
                        end
                    end else begin
                        cnt_d  = s_axis_h2c_tlast ? '0 : cnt_q + CW'(1);
                        ferr_d = s_axis_h2c_tlast;
                    end
                end
            end
            HOLD: begin
                if (slot_free) begin
                    load    = 1'b1;
                    state_d = COLLECT;
                end
            end
            DISCARD: begin
                if (accept && s_axis_h2c_tlast) begin
                    state_d = COLLECT;
                end
            end
            default: begin
                state_d = COLLECT;
                cnt_d   = '0;
            end
        endcase
    end

    // Sequence check resyncs to the received byte so one gap
    // produces exactly one error pulse.
    always_comb begin
        dv_d   = load | (dv_q & ~data_ready);
        data_d = load ? asm_d[8 +: DATA_WIDTH] : data_q;
        seq_d  = load ? asm_d[7:0] : seq_q;
        serr_d = load & (asm_d[7:0] != exp_q);
        exp_d  = load ? asm_d[7:0] + 8'd1 : exp_q;
        fcnt_d = fcnt_q + {15'd0, dv_q & data_ready};
    end

    always_ff @(posedge s_axis_h2c_aclk) begin
        if (s_axis_h2c_areset) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            data_q  <= '0;
            seq_q   <= '0;
            exp_q   <= '0;
            dv_q    <= 1'b0;
            ferr_q  <= 1'b0;
            serr_q  <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            seq_q   <= seq_d;
            exp_q   <= exp_d;
            dv_q    <= dv_d;
            ferr_q  <= ferr_d;
            serr_q  <= serr_d;
            fcnt_q  <= fcnt_d;
        end
    end

    always_ff @(posedge s_axis_h2c_aclk) begin
        asm_q <= asm_d;
    end

    assign data       = data_q;
    assign data_valid = dv_q;
    assign seq_num    = seq_q;
    assign frame_err  = ferr_q;
    assign seq_err    = serr_q;
    assign frame_cnt  = fcnt_q;
    assign ustate     = state_q;

endmodule

// File: tb/tb_axis_data_unpack.sv
// Self-checking bench for axis_data_unpack: frame-level reference
// model compared every cycle, plus directed literal checks.
module tb_axis_data_unpack;

    localparam int DW = 4064;
    localparam int AW = 512;
    localparam int NB = 8;
    localparam int SW = NB * AW;

    logic          clk;
    logic          areset;
    logic [AW-1:0] tdata;
    logic [AW/8-1:0] tkeep;
    logic          tlast;
    logic          tvalid;
    logic          tready;
    logic [DW-1:0] data;
    logic          data_valid;
    logic          data_ready;
    logic [7:0]    seq_num;
    logic          frame_err;
    logic          seq_err;
    logic [15:0]   frame_cnt;
    logic [1:0]    ustate;

    axis_data_unpack #(.DATA_WIDTH(DW), .AXIS_DATA_WIDTH(AW)) dut (
        .s_axis_h2c_aclk  (clk),
        .s_axis_h2c_areset(areset),
        .s_axis_h2c_tdata (tdata),
        .s_axis_h2c_tkeep (tkeep),
        .s_axis_h2c_tlast (tlast),
        .s_axis_h2c_tvalid(tvalid),
        .s_axis_h2c_tready(tready),
        .data             (data),
        .data_valid       (data_valid),
        .data_ready       (data_ready),
        .seq_num          (seq_num),
        .frame_err        (frame_err),
        .seq_err          (seq_err),
        .frame_cnt        (frame_cnt),
        .ustate           (ustate)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_bad  = 0;
    int n_serr = 0;
    int n_ferr = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic chkw(input string nm, input logic [DW-1:0] act,
                        input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got low %h expected low %h at %0t",
                     nm, act[63:0], exp[63:0], $time);
        end
    endtask

    function automatic logic [DW-1:0] pl(input logic [7:0] tag);
        logic [DW-1:0] p;
        for (int i = 0; i < DW / 32; i++)
            p[i*32 +: 32] = {tag, 8'hA5, 16'(i)};
        return p;
    endfunction

    // Stream image: seq byte at bit 0, payload above it, pad bits on top.
    function automatic logic [SW-1:0] mk(input logic [7:0] s,
                                         input logic [7:0] tag);
        return {{(SW-DW-8){1'b1}}, pl(tag), s};
    endfunction

    // ---------------- reference model ----------------
    logic [AW-1:0] m_beats[$];
    bit            m_disc    = 0;
    bit            m_hold    = 0;
    bit            m_full    = 0;
    bit            m_ferr    = 0;
    bit            m_serr    = 0;
    bit            m_started = 0;
    logic [DW-1:0] m_pdata   = '0;
    logic [DW-1:0] m_odata   = '0;
    logic [7:0]    m_pseq    = '0;
    logic [7:0]    m_oseq    = '0;
    logic [7:0]    m_exp     = '0;
    int            m_fcnt    = 0;

    initial forever begin : model
        bit fire;
        bit free;
        bit ld;
        logic [SW-1:0] cat;
        @(posedge clk);
        m_started = 1;
        if (areset) begin
            m_beats.delete();
            m_disc = 0; m_hold = 0; m_full = 0;
            m_ferr = 0; m_serr = 0; m_fcnt = 0;
            m_exp = '0; m_oseq = '0; m_odata = '0;
        end else begin
            fire = m_full && data_ready;
            free = !m_full || data_ready;
            ld = 0; m_ferr = 0; m_serr = 0;
            if (m_hold) begin
                if (free) ld = 1;
            end else if (tvalid) begin
                if (m_disc) begin
                    if (tlast) m_disc = 0;
                end else begin
                    m_beats.push_back(tdata);
                    if (m_beats.size() < NB) begin
                        if (tlast) begin
                            m_ferr = 1;
                            m_beats.delete();
                        end
                    end else if (!tlast) begin
                        m_ferr = 1;
                        m_disc = 1;
                        m_beats.delete();
                    end else begin
                        cat = '0;
                        foreach (m_beats[k]) cat[k*AW +: AW] = m_beats[k];
                        m_pdata = cat[8 +: DW];
                        m_pseq  = cat[7:0];
                        m_beats.delete();
                        if (free) ld = 1;
                        else m_hold = 1;
                    end
                end
            end
            if (fire) begin
                m_fcnt = (m_fcnt + 1) % 65536;
                m_full = 0;
            end
            if (ld) begin
                m_full = 1;
                m_odata = m_pdata;
                m_oseq = m_pseq;
                m_serr = (m_pseq != m_exp);
                m_exp = m_pseq + 8'd1;
                m_hold = 0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin : compare
        @(negedge clk);
        if (m_started) begin
            chk("tready", 64'(tready), 64'(!areset && !m_hold));
            chk("data_valid", 64'(data_valid), 64'(m_full));
            chkw("data", data, m_odata);
            chk("seq_num", 64'(seq_num), 64'(m_oseq));
            chk("frame_err", 64'(frame_err), 64'(m_ferr));
            chk("seq_err", 64'(seq_err), 64'(m_serr));
            chk("frame_cnt", 64'(frame_cnt), 64'(m_fcnt[15:0]));
            chk("ustate", 64'(ustate), 64'(m_hold ? 1 : (m_disc ? 2 : 0)));
            if (seq_err) n_serr++;
            if (frame_err) n_ferr++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [AW-1:0] d, input logic l);
        bit acc;
        int guard;
        tvalid = 1'b1;
        tdata  = d;
        tlast  = l;
        guard  = 0;
        acc    = 0;
        while (!acc && guard < 200) begin
            @(negedge clk);
            acc = tready;
            @(posedge clk);
            #1;
            guard++;
        end
        chk("beat_accept", 64'(acc), 64'd1);
    endtask

    task automatic send_frame(input logic [7:0] s, input logic [7:0] tag,
                              input int nbeats, input int last_at);
        logic [SW-1:0] st;
        logic [AW-1:0] b;
        st = mk(s, tag);
        for (int k = 0; k < nbeats; k++) begin
            if (k < NB) b = st[k*AW +: AW];
            else b = {(AW/32){32'hDEADBEEF}};
            beat(b, k == last_at);
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        tick();
        tick();
        areset = 1'b0;
    endtask

    initial begin : timeout
        #200000;
        $display("FAIL timeout: run did not finish");
        $fatal(1);
    end

    initial begin : main
        int base;
        time t0;
        logic [SW-1:0] st;
        areset     = 1'b1;
        tvalid     = 1'b0;
        tdata      = '0;
        tlast      = 1'b0;
        tkeep      = '1;
        data_ready = 1'b1;
        repeat (3) tick();
        chk("rst_tready", 64'(tready), 64'd0);
        chk("rst_dv", 64'(data_valid), 64'd0);
        chk("rst_fcnt", 64'(frame_cnt), 64'd0);
        chk("rst_ustate", 64'(ustate), 64'd0);
        areset = 1'b0;
        tick();

        // Single frame, seq 0x00
        send_frame(8'h00, 8'h11, 8, 7);
        chk("t1_latency_dv", 64'(data_valid), 64'd1);
        chk("t1_data_lo", 64'(data[31:0]), 64'h11A50000);
        chk("t1_data_hi", 64'(data[DW-1 -: 32]), 64'h11A5007E);
        chk("t1_seq", 64'(seq_num), 64'h00);
        chkw("t1_model_pin", m_odata, pl(8'h11));
        tick();
        chk("t1_fcnt", 64'(frame_cnt), 64'd1);
        chk("t1_no_err", 64'(n_serr + n_ferr), 64'd0);

        // Back-to-back 0x00, 0x01, 0x03 at full rate
        do_reset();
        t0 = $time;
        send_frame(8'h00, 8'h21, 8, 7);
        send_frame(8'h01, 8'h22, 8, 7);
        send_frame(8'h03, 8'h23, 8, 7);
        chk("t2_cycles", 64'(($time - t0) / 10), 64'd24);
        tick();
        chk("t2_fcnt", 64'(frame_cnt), 64'd3);
        chk("t2_serr_once", 64'(n_serr), 64'd1);
        send_frame(8'h04, 8'h24, 8, 7);
        tick();
        chk("t2_exp_04", 64'(n_serr), 64'd1);

        // Backpressure: second frame completes while first is held
        data_ready = 1'b0;
        send_frame(8'h05, 8'h33, 8, 7);
        send_frame(8'h06, 8'h44, 8, 7);
        chk("t3_hold", 64'(ustate), 64'd1);
        chk("t3_tready0", 64'(tready), 64'd0);
        repeat (3) tick();
        chk("t3_stable_lo", 64'(data[31:0]), 64'h33A50000);
        chk("t3_stable_seq", 64'(seq_num), 64'h05);
        data_ready = 1'b1;
        tick();
        chk("t3_second_seq", 64'(seq_num), 64'h06);
        chk("t3_second_lo", 64'(data[31:0]), 64'h44A50000);
        tick();
        chk("t3_fcnt", 64'(frame_cnt), 64'd6);

        // Short frame, tlast on beat 3
        base = n_ferr;
        send_frame(8'h07, 8'h55, 4, 3);
        tick();
        chk("t4_ferr", 64'(n_ferr - base), 64'd1);
        chk("t4_nothing", 64'(data_valid), 64'd0);
        send_frame(8'h07, 8'h66, 8, 7);
        chk("t4_good_seq", 64'(seq_num), 64'h07);
        chk("t4_good_lo", 64'(data[31:0]), 64'h66A50000);
        tick();

        // Long frame: 10 beats, tlast on beat 9
        base = n_ferr;
        send_frame(8'h08, 8'h77, 10, 9);
        tick();
        chk("t5_ferr", 64'(n_ferr - base), 64'd1);
        chk("t5_nothing", 64'(data_valid), 64'd0);
        send_frame(8'h08, 8'h88, 8, 7);
        chk("t5_good_seq", 64'(seq_num), 64'h08);
        chk("t5_good_lo", 64'(data[31:0]), 64'h88A50000);
        tick();
        chk("t5_serr_total", 64'(n_serr), 64'd1);

        // Reset after beat 4 of a partial frame
        st = mk(8'h09, 8'h99);
        for (int k = 0; k < 5; k++) beat(st[k*AW +: AW], 1'b0);
        tvalid = 1'b0;
        do_reset();
        chk("t6_dv", 64'(data_valid), 64'd0);
        chk("t6_fcnt", 64'(frame_cnt), 64'd0);
        base = n_serr;
        send_frame(8'h00, 8'hAA, 8, 7);
        chk("t6_seq", 64'(seq_num), 64'h00);
        chk("t6_lo", 64'(data[31:0]), 64'hAAA50000);
        tick();
        chk("t6_no_serr", 64'(n_serr - base), 64'd0);
        chk("t6_fcnt1", 64'(frame_cnt), 64'd1);

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
